// File: rtl/lw_sha_msg_sequencer.sv
// lw_sha_msg_sequencer: feeds 32-bit message words to the lightweight SHA-256
// core and appends the padding in hardware: the 0x80 marker, the zero fill
// and the 64-bit big-endian bit length.
// Optional build macro LW_SHA_SEQ_BYTE_SWAP_EN: when defined, incoming words
// are little-endian and are byte-swapped before masking and marker insertion.
module lw_sha_msg_sequencer #(
    parameter int unsigned BLOCK_WORDS  = 16,
    parameter int unsigned LEN_W        = 64,
    parameter int unsigned DONE_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        msg_start_i,
    input  logic        msg_empty_i,
    input  logic [31:0] msg_data_i,
    input  logic        msg_valid_i,
    input  logic        msg_last_i,
    input  logic [2:0]  msg_nbytes_i,
    output logic        msg_ready_o,
    output logic [31:0] core_data_o,
    output logic        core_valid_o,
    input  logic        core_ready_i,
    output logic        core_start_o,
    output logic        core_last_o,
    output logic        core_abort_o,
    input  logic        core_done_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAD,
        S_ZERO,
        S_LENHI,
        S_LENLO,
        S_WAIT_DONE
    } state_t;

    // Loading a fill word at this index means the next slot is the length-high
    // word, so the fill ends here and the length pair follows.
    localparam logic [3:0] FILL_END_IDX = 4'(BLOCK_WORDS - 3);

    state_t             state_reg, state_next;
    logic [3:0]         widx_reg, widx_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic               empty_reg, empty_next;
    logic               lo_sent_reg, lo_sent_next;
    logic [31:0]        tmo_cnt_reg, tmo_cnt_next;
    logic               valid_reg, valid_next;
    logic [31:0]        data_reg, data_next;
    logic               err_reg, err_next;
    logic               done_reg, done_next;
    logic               abort_reg, abort_next;

    logic               msg_ready;
    logic               core_last;
    logic               accept;
    logic               load_ok;
    logic [3:0]         load_idx;
    logic [31:0]        word_in;
    logic [31:0]        last_word;
    logic               nbytes_bad;
    logic [2:0]         nb_eff;

`ifdef LW_SHA_SEQ_BYTE_SWAP_EN
    // Little-endian source: byte at [7:0] becomes byte0 at [31:24].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_swap
            assign word_in[8*gi +: 8] = msg_data_i[8*(3-gi) +: 8];
        end
    endgenerate
`else
    assign word_in = msg_data_i;
`endif

    // Core-side handshake helpers; a new word enters the output register at
    // index widx, or widx+1 when the word currently held is leaving this cycle.
    assign accept   = valid_reg && core_ready_i;
    assign load_ok  = !valid_reg || core_ready_i;
    assign load_idx = widx_reg + {3'b000, valid_reg};

    // Illegal byte counts are treated as a full word (and flagged as an error).
    assign nbytes_bad = (msg_nbytes_i == 3'd0) || (msg_nbytes_i > 3'd4);
    assign nb_eff     = nbytes_bad ? 3'd4 : msg_nbytes_i;

    // Final word: keep the valid leading bytes, put 0x80 right after them.
    always_comb begin
        last_word = word_in;
        case (nb_eff)
            3'd1:    last_word = {word_in[31:24], 8'h80, 16'h0000};
            3'd2:    last_word = {word_in[31:16], 8'h80, 8'h00};
            3'd3:    last_word = {word_in[31:8], 8'h80};
            default: last_word = word_in;
        endcase
    end

    // Next-state, datapath and combinational handshake outputs.
    always_comb begin
        state_next   = state_reg;
        widx_next    = widx_reg;
        len_next     = len_reg;
        empty_next   = empty_reg;
        lo_sent_next = lo_sent_reg;
        tmo_cnt_next = tmo_cnt_reg;
        valid_next   = valid_reg;
        data_next    = data_reg;
        err_next     = err_reg;
        done_next    = 1'b0;
        abort_next   = 1'b0;
        msg_ready    = 1'b0;
        core_last    = 1'b0;

        if (accept) begin
            valid_next = 1'b0;
            widx_next  = widx_reg + 4'd1;
        end

        case (state_reg)
            S_IDLE: begin
                if (msg_start_i) begin
                    state_next   = S_START;
                    len_next     = '0;
                    widx_next    = 4'd0;
                    err_next     = 1'b0;
                    empty_next   = msg_empty_i;
                    lo_sent_next = 1'b0;
                    tmo_cnt_next = 32'd0;
                end
            end
            S_START: begin
                state_next = empty_reg ? S_PAD : S_DATA;
            end
            S_DATA: begin
                msg_ready = load_ok;
                if (msg_valid_i && load_ok) begin
                    valid_next = 1'b1;
                    if (!msg_last_i) begin
                        data_next = word_in;
                        len_next  = len_reg + LEN_W'(32);
                    end else begin
                        data_next = last_word;
                        len_next  = len_reg + LEN_W'({nb_eff, 3'b000});
                        if (nbytes_bad) begin
                            err_next = 1'b1;
                        end
                        if (nb_eff == 3'd4) begin
                            state_next = S_PAD;
                        end else begin
                            state_next = (load_idx == FILL_END_IDX) ? S_LENHI : S_ZERO;
                        end
                    end
                end
            end
            S_PAD: begin
                if (load_ok) begin
                    valid_next = 1'b1;
                    data_next  = 32'h8000_0000;
                    state_next = (load_idx == FILL_END_IDX) ? S_LENHI : S_ZERO;
                end
            end
            S_ZERO: begin
                if (load_ok) begin
                    valid_next = 1'b1;
                    data_next  = 32'h0000_0000;
                    state_next = (load_idx == FILL_END_IDX) ? S_LENHI : S_ZERO;
                end
            end
            S_LENHI: begin
                if (load_ok) begin
                    valid_next   = 1'b1;
                    data_next    = len_reg[LEN_W-1:32];
                    lo_sent_next = 1'b0;
                    state_next   = S_LENLO;
                end
            end
            S_LENLO: begin
                // First load the low length word, then wait for the core to take it.
                if (!lo_sent_reg) begin
                    if (load_ok) begin
                        valid_next   = 1'b1;
                        data_next    = len_reg[31:0];
                        lo_sent_next = 1'b1;
                    end
                end else if (accept) begin
                    core_last    = 1'b1;
                    state_next   = S_WAIT_DONE;
                    tmo_cnt_next = 32'd0;
                end
            end
            S_WAIT_DONE: begin
                if (core_done_i) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else if ((DONE_TIMEOUT != 0) && (tmo_cnt_reg == DONE_TIMEOUT - 32'd1)) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 32'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Software abort overrides everything else while a message is active.
        if (abort_i && (state_reg != S_IDLE)) begin
            state_next   = S_IDLE;
            valid_next   = 1'b0;
            data_next    = data_reg;
            widx_next    = 4'd0;
            len_next     = '0;
            lo_sent_next = 1'b0;
            tmo_cnt_next = 32'd0;
            err_next     = err_reg;
            done_next    = 1'b0;
            abort_next   = 1'b1;
            msg_ready    = 1'b0;
            core_last    = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            widx_reg    <= 4'd0;
            len_reg     <= '0;
            empty_reg   <= 1'b0;
            lo_sent_reg <= 1'b0;
            tmo_cnt_reg <= 32'd0;
            valid_reg   <= 1'b0;
            data_reg    <= 32'd0;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
            abort_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            widx_reg    <= widx_next;
            len_reg     <= len_next;
            empty_reg   <= empty_next;
            lo_sent_reg <= lo_sent_next;
            tmo_cnt_reg <= tmo_cnt_next;
            valid_reg   <= valid_next;
            data_reg    <= data_next;
            err_reg     <= err_next;
            done_reg    <= done_next;
            abort_reg   <= abort_next;
        end
    end

    assign msg_ready_o  = msg_ready;
    assign core_data_o  = data_reg;
    assign core_valid_o = valid_reg;
    assign core_start_o = (state_reg == S_START) && !abort_i;
    assign core_last_o  = core_last;
    assign core_abort_o = abort_reg;
    assign busy_o       = (state_reg != S_IDLE);
    assign done_o       = done_reg;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_lw_sha_msg_sequencer.sv
// Directed bench for lw_sha_msg_sequencer (default build, no byte swap).
// A table of messages with hand-computed padded streams, plus hand-written
// sequences for abort, done timeout and reset mid-message.
module tb_lw_sha_msg_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        msg_start_i = 1'b0;
    logic        msg_empty_i = 1'b0;
    logic [31:0] msg_data_i = 32'd0;
    logic        msg_valid_i = 1'b0;
    logic        msg_last_i = 1'b0;
    logic [2:0]  msg_nbytes_i = 3'd0;
    logic        msg_ready_o;
    logic [31:0] core_data_o;
    logic        core_valid_o;
    logic        core_ready_i;
    logic        core_start_o;
    logic        core_last_o;
    logic        core_abort_o;
    logic        core_done_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int tests_run = 0;
    int tests_failed = 0;

    lw_sha_msg_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .msg_start_i  (msg_start_i),
        .msg_empty_i  (msg_empty_i),
        .msg_data_i   (msg_data_i),
        .msg_valid_i  (msg_valid_i),
        .msg_last_i   (msg_last_i),
        .msg_nbytes_i (msg_nbytes_i),
        .msg_ready_o  (msg_ready_o),
        .core_data_o  (core_data_o),
        .core_valid_o (core_valid_o),
        .core_ready_i (core_ready_i),
        .core_start_o (core_start_o),
        .core_last_o  (core_last_o),
        .core_abort_o (core_abort_o),
        .core_done_i  (core_done_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial forever #5 clk = ~clk;

    // Message vector: stimulus plus hand-computed expected stream layout.
    typedef struct packed {
        logic        empty;
        logic [4:0]  nwords;
        logic [2:0]  nbytes;
        logic        stall;
        logic        pad;       // a separate 0x80000000 word follows the data
        logic [5:0]  total;     // total words sent to the core
        logic [31:0] base;      // data word i = base + i
        logic [31:0] exp_last;  // expected final data word after masking
        logic [31:0] exp_len;   // expected low length word
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [0:NVEC-1];

    // Core ready driver: constant 1, or the repeating 1-0-0-1 backpressure pattern.
    bit stall_en = 1'b0;
    int phase = 0;
    initial begin
        core_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                core_ready_i = ((phase % 4) == 0) || ((phase % 4) == 3);
                phase++;
            end else begin
                core_ready_i = 1'b1;
            end
        end
    end

    // Monitor: records every word the core accepts and counts pulses/violations.
    logic [31:0] got_words [0:1023];
    int got_n = 0;
    int start_cnt = 0;
    int last_cnt = 0;
    int last_at = -1;
    int done_cnt = 0;
    int abort_cnt = 0;
    int viol_cnt = 0;
    initial begin
        bit          prev_stall;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (core_valid_o && core_ready_i) begin
                    if (core_last_o) last_at = got_n;
                    if (got_n < 1024) got_words[got_n] = core_data_o;
                    got_n++;
                end
                if (core_start_o) start_cnt++;
                if (core_last_o)  last_cnt++;
                if (done_o)       done_cnt++;
                if (core_abort_o) abort_cnt++;
                if (prev_stall && (!core_valid_o || core_data_o != prev_data)) viol_cnt++;
                if (core_valid_o && !core_ready_i && msg_ready_o) viol_cnt++;
                prev_stall = core_valid_o && !core_ready_i;
                prev_data  = core_data_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_msg(input bit empty);
        msg_start_i = 1'b1;
        msg_empty_i = empty;
        @(posedge clk);
        #1;
        msg_start_i = 1'b0;
        msg_empty_i = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] base, input int n, input bit mark_last,
                              input logic [2:0] nb_last, output bit ok);
        int budget;
        ok = 1'b1;
        for (int i = 0; i < n && ok; i++) begin
            msg_valid_i  = 1'b1;
            msg_data_i   = base + 32'(i);
            msg_last_i   = mark_last && (i == n - 1);
            msg_nbytes_i = msg_last_i ? nb_last : 3'd4;
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!msg_ready_o && budget < 200);
            if (!msg_ready_o) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        msg_valid_i  = 1'b0;
        msg_last_i   = 1'b0;
        msg_nbytes_i = 3'd0;
        msg_data_i   = 32'd0;
    endtask

    // Run one table message; give_done=0 withholds core_done_i to hit the timeout.
    task automatic run_vec(input int v, input bit give_done);
        vec_t        r;
        logic [31:0] exp_w [0:31];
        int          n, total, base_n, base_start, base_last, base_done, base_viol, budget;
        bit          ok;
        r = vecs[v];
        n = int'(r.nwords);
        total = int'(r.total);
        for (int i = 0; i < 32; i++) exp_w[i] = 32'h0;
        for (int i = 0; i < n; i++) exp_w[i] = r.base + 32'(i);
        if (n > 0) exp_w[n-1] = r.exp_last;
        if (r.pad) exp_w[n] = 32'h8000_0000;
        exp_w[total-1] = r.exp_len;

        base_n     = got_n;
        base_start = start_cnt;
        base_last  = last_cnt;
        base_done  = done_cnt;
        base_viol  = viol_cnt;
        stall_en   = r.stall;

        start_msg(r.empty);
        send_words(r.base, n, 1'b1, r.nbytes, ok);
        check($sformatf("v%0d_send_ok", v), 32'(ok), 32'd1);

        budget = 0;
        while (last_cnt == base_last && budget < 600) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("v%0d_last_cnt", v), 32'(last_cnt - base_last), 32'd1);

        if (give_done) begin
            repeat (2) @(posedge clk);
            #1;
            core_done_i = 1'b1;
            @(posedge clk);
            #1;
            core_done_i = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), 32'(done_o), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_done_end", v), 32'(done_o), 32'd0);
            check($sformatf("v%0d_busy_end", v), 32'(busy_o), 32'd0);
            check($sformatf("v%0d_err", v), 32'(err_o), 32'(r.exp_err));
        end else begin
            repeat (1000) @(negedge clk);
            check($sformatf("v%0d_tmo_busy_early", v), 32'(busy_o), 32'd1);
            check($sformatf("v%0d_tmo_err_early", v), 32'(err_o), 32'd0);
            repeat (40) @(negedge clk);
            check($sformatf("v%0d_tmo_busy", v), 32'(busy_o), 32'd0);
            check($sformatf("v%0d_tmo_err", v), 32'(err_o), 32'd1);
            check($sformatf("v%0d_tmo_no_done", v), 32'(done_cnt - base_done), 32'd0);
        end
        stall_en = 1'b0;

        check($sformatf("v%0d_word_count", v), 32'(got_n - base_n), 32'(total));
        for (int i = 0; i < total; i++) begin
            check($sformatf("v%0d_word%0d", v, i), got_words[base_n + i], exp_w[i]);
        end
        check($sformatf("v%0d_start_cnt", v), 32'(start_cnt - base_start), 32'd1);
        check($sformatf("v%0d_last_pos", v), 32'(last_at - base_n), 32'(total - 1));
        check($sformatf("v%0d_stall_viol", v), 32'(viol_cnt - base_viol), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int base_n;

        //              empty nw     nb    stall pad  total  base          exp_last      exp_len       err
        vecs[0] = '{1'b0, 5'd1,  3'd3, 1'b0, 1'b0, 6'd16, 32'h61626300, 32'h61626380, 32'h00000018, 1'b0};
        vecs[1] = '{1'b1, 5'd0,  3'd4, 1'b0, 1'b1, 6'd16, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[2] = '{1'b0, 5'd14, 3'd3, 1'b0, 1'b0, 6'd16, 32'h11223344, 32'h11223380, 32'h000001B8, 1'b0};
        vecs[3] = '{1'b0, 5'd14, 3'd4, 1'b0, 1'b1, 6'd32, 32'h11223344, 32'h11223351, 32'h000001C0, 1'b0};
        vecs[4] = '{1'b0, 5'd1,  3'd3, 1'b1, 1'b0, 6'd16, 32'h61626300, 32'h61626380, 32'h00000018, 1'b0};
        vecs[5] = '{1'b0, 5'd1,  3'd0, 1'b0, 1'b1, 6'd16, 32'h01020304, 32'h01020304, 32'h00000020, 1'b1};
        vecs[6] = '{1'b0, 5'd2,  3'd1, 1'b0, 1'b0, 6'd16, 32'hAABBCC00, 32'hAA800000, 32'h00000028, 1'b0};
        vecs[7] = '{1'b0, 5'd15, 3'd2, 1'b1, 1'b0, 6'd32, 32'h10000000, 32'h10008000, 32'h000001D0, 1'b0};
        vecs[8] = '{1'b0, 5'd16, 3'd4, 1'b1, 1'b1, 6'd32, 32'h20000000, 32'h2000000F, 32'h00000200, 1'b0};

        // Reset state
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_valid", 32'(core_valid_o), 32'd0);
        check("rst_core_data", core_data_o, 32'd0);
        check("rst_core_start", 32'(core_start_o), 32'd0);
        check("rst_core_last", 32'(core_last_o), 32'd0);
        check("rst_core_abort", 32'(core_abort_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_msg_ready", 32'(msg_ready_o), 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < NVEC; v++) begin
            run_vec(v, 1'b1);
        end

        // Abort while idle has no effect.
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        @(negedge clk);
        check("idle_abort_pulse", 32'(core_abort_o), 32'd0);
        check("idle_abort_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;

        // Abort in DATA after five words have reached the core (widx=5).
        base_n = got_n;
        start_msg(1'b0);
        send_words(32'h55500000, 5, 1'b0, 3'd4, ok);
        check("abort_send_ok", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("abort_pre_words", 32'(got_n - base_n), 32'd5);
        check("abort_pre_busy", 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        @(negedge clk);
        check("abort_pulse", 32'(core_abort_o), 32'd1);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_valid", 32'(core_valid_o), 32'd0);
        @(negedge clk);
        check("abort_pulse_end", 32'(core_abort_o), 32'd0);
        @(posedge clk);
        #1;
        run_vec(0, 1'b1);

        // core_done_i withheld: timeout sets err and returns to idle; next start clears err.
        run_vec(0, 1'b0);
        run_vec(1, 1'b1);

        // Reset mid-message: back to the reset state without an abort pulse.
        start_msg(1'b0);
        send_words(32'h77700000, 3, 1'b0, 3'd4, ok);
        check("mrst_send_ok", 32'(ok), 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_valid", 32'(core_valid_o), 32'd0);
        check("mrst_abort", 32'(core_abort_o), 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        run_vec(0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
